// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB control with
// trap steering (ecall, illegal opcode, memory timeout) and a retired-instruction counter.
module core_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        halt_req,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic [1:0]  cause,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [1:0] CAUSE_ECALL   = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [TO_W-1:0] WAIT_LIMIT = TO_W'(TIMEOUT - 1);

    logic [2:0]      state_q, state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic [1:0]      cause_q, cause_nxt;
    logic [31:0]     instret_q;
    logic            timeout_hit;

    logic is_load, is_store, is_branch, is_jump, is_ecall, is_illegal;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_branch  = 1'b0;
        is_jump    = 1'b0;
        is_ecall   = 1'b0;
        is_illegal = 1'b0;
        case (inst[6:0])
            7'b0000011: is_load   = 1'b1;
            7'b0100011: is_store  = 1'b1;
            7'b1100011: is_branch = 1'b1;
            7'b1101111,
            7'b1100111: is_jump   = 1'b1;
            7'b0110011,
            7'b0010011,
            7'b0110111,
            7'b0010111: ;
            // Only the exact ECALL encoding is accepted in the SYSTEM space
            7'b1110011: begin
                if (inst == 32'h0000_0073) is_ecall   = 1'b1;
                else                       is_illegal = 1'b1;
            end
            default:    is_illegal = 1'b1;
        endcase
    end

    assign timeout_hit = (wait_cnt == WAIT_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        cause_nxt = cause_q;
        case (state_q)
            S_FETCH: begin
                // A ready arriving on the limit cycle beats the timeout
                if (imem_ready) begin
                    state_nxt = S_DECODE;
                end else if (timeout_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (is_ecall) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ECALL;
                end else if (is_illegal) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC:  state_nxt = (is_load || is_store) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    state_nxt = S_WB;
                end else if (timeout_hit) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_WB, S_TRAP, S_HALT: state_nxt = halt_req ? S_HALT : S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            cause_q   <= 2'd0;
            instret_q <= 32'd0;
        end else begin
            // Any state change restarts the wait window for the next FETCH/MEM
            if (state_nxt != state_q)
                wait_cnt <= '0;
            else if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
                wait_cnt <= wait_cnt + 1'b1;
            if (state_nxt == S_TRAP && state_q != S_TRAP)
                cause_q <= cause_nxt;
            if (state_q == S_WB)
                instret_q <= instret_q + 32'd1;
        end
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        trap     = 1'b0;
        // Strobes are forced low for the whole reset pulse, not just after the edge
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                S_WB: begin
                    pc_we = 1'b1;
                    rf_we = !(is_store || is_branch);
                    if (is_branch)    pc_sel = 2'b01;
                    else if (is_jump) pc_sel = 2'b10;
                end
                S_TRAP: begin
                    pc_we  = 1'b1;
                    pc_sel = 2'b11;
                    trap   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cause   = cause_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: walks each instruction class, trap path,
// halt and asynchronous reset with hand-computed expectations.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst;
    logic        imem_ready, dmem_ready, halt_req;
    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap;
    logic [1:0]  pc_sel, cause;
    logic [2:0]  state;
    logic [31:0] instret;

    int n_checks = 0;
    int n_errors = 0;

    core_sequencer #(.TIMEOUT(4), .TO_W(3)) dut (
        .clk(clk), .reset(reset), .inst(inst),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .halt_req(halt_req),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap),
        .cause(cause), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are observed 1-2 units after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_idle_strobes(input string tag);
        check({tag, " imem_req"}, 32'(imem_req), 32'd0);
        check({tag, " ir_we"},    32'(ir_we),    32'd0);
        check({tag, " dmem_req"}, 32'(dmem_req), 32'd0);
        check({tag, " dmem_we"},  32'(dmem_we),  32'd0);
        check({tag, " rf_we"},    32'(rf_we),    32'd0);
        check({tag, " pc_we"},    32'(pc_we),    32'd0);
        check({tag, " pc_sel"},   32'(pc_sel),   32'd0);
        check({tag, " trap"},     32'(trap),     32'd0);
    endtask

    // Zero-wait fetch of instr: FETCH cycle then lands in DECODE
    task automatic fetch_now(input string tag, input logic [31:0] instr);
        inst = instr;
        imem_ready = 1'b1;
        settle();
        check({tag, " fetch state"}, 32'(state), 32'd0);
        check({tag, " ir_we"}, 32'(ir_we), 32'd1);
        tick();
        imem_ready = 1'b0;
        settle();
        check({tag, " decode state"}, 32'(state), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        inst = 32'h0000_0013;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        halt_req = 1'b0;
        #2;
        check("rst state", 32'(state), 32'd0);
        check("rst instret", instret, 32'd0);
        check("rst cause", 32'(cause), 32'd0);
        check_idle_strobes("rst");
        imem_ready = 1'b0;
        tick();
        reset = 1'b0;

        // OP-IMM, zero wait: 0,1,2,4,0
        fetch_now("opimm", 32'h0010_0093);
        tick(); settle();
        check("opimm exec", 32'(state), 32'd2);
        tick(); settle();
        check("opimm wb", 32'(state), 32'd4);
        check("opimm rf_we", 32'(rf_we), 32'd1);
        check("opimm pc_we", 32'(pc_we), 32'd1);
        check("opimm pc_sel", 32'(pc_sel), 32'd0);
        check("opimm instret pre", instret, 32'd0);
        tick(); settle();
        check("opimm back", 32'(state), 32'd0);
        check("opimm instret", instret, 32'd1);

        // STORE with three dmem wait cycles: 8 cycles total
        fetch_now("store", 32'h0011_2023);
        tick(); settle();
        check("store exec", 32'(state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            dmem_ready = (i == 3);
            settle();
            check($sformatf("store mem%0d state", i), 32'(state), 32'd3);
            check($sformatf("store mem%0d req", i), 32'(dmem_req), 32'd1);
            check($sformatf("store mem%0d we", i), 32'(dmem_we), 32'd1);
        end
        tick();
        dmem_ready = 1'b0;
        settle();
        check("store wb", 32'(state), 32'd4);
        check("store rf_we", 32'(rf_we), 32'd0);
        check("store pc_we", 32'(pc_we), 32'd1);
        check("store dmem_req", 32'(dmem_req), 32'd0);
        tick(); settle();
        check("store back", 32'(state), 32'd0);
        check("store instret", instret, 32'd2);

        // ECALL trap
        fetch_now("ecall", 32'h0000_0073);
        tick(); settle();
        check("ecall state", 32'(state), 32'd5);
        check("ecall trap", 32'(trap), 32'd1);
        check("ecall pc_sel", 32'(pc_sel), 32'd3);
        check("ecall pc_we", 32'(pc_we), 32'd1);
        check("ecall rf_we", 32'(rf_we), 32'd0);
        check("ecall cause", 32'(cause), 32'd1);
        tick(); settle();
        check("ecall back", 32'(state), 32'd0);
        check("ecall instret", instret, 32'd2);

        // Illegal opcode 1111111
        fetch_now("illegal", 32'h0000_007F);
        tick(); settle();
        check("illegal state", 32'(state), 32'd5);
        check("illegal cause", 32'(cause), 32'd2);
        check("illegal trap", 32'(trap), 32'd1);
        tick(); settle();
        check("illegal back", 32'(state), 32'd0);

        // imem timeout: four FETCH cycles then TRAP
        inst = 32'h0010_0093;
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("to fetch%0d", i), 32'(state), 32'd0);
            check($sformatf("to imem_req%0d", i), 32'(imem_req), 32'd1);
            tick();
        end
        settle();
        check("to state", 32'(state), 32'd5);
        check("to cause", 32'(cause), 32'd3);
        check("to pc_sel", 32'(pc_sel), 32'd3);
        tick(); settle();
        check("to back", 32'(state), 32'd0);

        // ready on the limit cycle wins over timeout
        for (int i = 0; i < 3; i++) tick();
        imem_ready = 1'b1;
        settle();
        check("late fetch state", 32'(state), 32'd0);
        check("late ir_we", 32'(ir_we), 32'd1);
        tick();
        imem_ready = 1'b0;
        settle();
        check("late decode", 32'(state), 32'd1);
        check("late trap", 32'(trap), 32'd0);
        tick(); tick(); settle();
        check("late wb", 32'(state), 32'd4);
        tick(); settle();
        check("late instret", instret, 32'd3);

        // JAL with halt request during WB
        fetch_now("jal", 32'h0080_006F);
        tick(); settle();
        check("jal exec", 32'(state), 32'd2);
        tick();
        halt_req = 1'b1;
        settle();
        check("jal wb", 32'(state), 32'd4);
        check("jal pc_sel", 32'(pc_sel), 32'd2);
        check("jal rf_we", 32'(rf_we), 32'd1);
        tick(); settle();
        check("halt state", 32'(state), 32'd6);
        check_idle_strobes("halt");
        check("halt instret", instret, 32'd4);
        tick(); settle();
        check("halt hold", 32'(state), 32'd6);
        halt_req = 1'b0;
        tick(); settle();
        check("halt exit", 32'(state), 32'd0);

        // Async reset in the 2nd MEM cycle of a LOAD
        fetch_now("load", 32'h0001_2083);
        tick(); tick(); settle();
        check("load mem1", 32'(state), 32'd3);
        check("load mem1 we", 32'(dmem_we), 32'd0);
        tick(); settle();
        check("load mem2", 32'(state), 32'd3);
        check("load mem2 req", 32'(dmem_req), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst state", 32'(state), 32'd0);
        check("arst dmem_req", 32'(dmem_req), 32'd0);
        check("arst imem_req", 32'(imem_req), 32'd0);
        check("arst instret", instret, 32'd0);
        check("arst cause", 32'(cause), 32'd0);
        #1;
        reset = 1'b0;
        settle();
        check("arst restart imem_req", 32'(imem_req), 32'd1);
        tick();
        fetch_now("refetch", 32'h0001_2083);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the PC unit's write enable and next-PC select. It sits between instruction/data memory handshakes and the datapath (instruction register, register file, PC unit). It also detects ECALL, illegal opcodes and memory timeouts and steers the PC to the trap vector. It keeps a retired-instruction counter.

## Interface
- `TIMEOUT`, 255: cycles to wait for `imem_ready`/`dmem_ready` before a timeout trap; minimum 2.
- `TO_W`, 8: width of the wait counter; must satisfy 2^TO_W > TIMEOUT.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `inst`  in  32  current instruction from the instruction register; stable from DECODE through WB.
- `imem_ready`  in  1  instruction memory has valid data this cycle.
- `dmem_ready`  in  1  data memory access completes this cycle.
- `halt_req`  in  1  debug halt request.
- `imem_req`  out  1  instruction fetch request.
- `ir_we`  out  1  instruction register load strobe.
- `dmem_req`  out  1  data memory request.
- `dmem_we`  out  1  data memory write (store).
- `rf_we`  out  1  register file write strobe.
- `pc_we`  out  1  PC register update strobe.
- `pc_sel`  out  2  next-PC select: 00 pc+4, 01 branch unit, 10 jump unit, 11 trap vector.
- `trap`  out  1  trap taken this cycle.
- `cause`  out  2  last trap cause: 0 none, 1 ecall, 2 illegal, 3 timeout.
- `state`  out  3  current FSM state encoding.
- `instret`  out  32  retired-instruction count.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, HALT=6. Encoding 7 is unreachable; if entered, go to FETCH.
- Instruction class comes from `inst[6:0]`:
  - LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - JAL 1101111, JALR 1100111.
  - OP 0110011, OP-IMM 0010011, LUI 0110111, AUIPC 0010111.
  - SYSTEM 1110011: only `inst == 32'h00000073` (ECALL) is legal.
  - Any other opcode is illegal.
- FETCH: `imem_req`=1. On `imem_ready`, `ir_we`=1 and go to DECODE.
- DECODE: ECALL goes to TRAP with cause 1. Illegal opcode goes to TRAP with cause 2. Everything else goes to EXEC.
- EXEC: one cycle. LOAD and STORE go to MEM; all other classes go to WB.
- MEM: `dmem_req`=1, and `dmem_we`=1 for STORE. On `dmem_ready`, go to WB.
- WB: `pc_we`=1 and `instret` increments.
  - `rf_we`=1 for all classes except STORE and BRANCH.
  - `pc_sel`: 01 for BRANCH (the branch unit resolves taken/not-taken), 10 for JAL/JALR, 00 otherwise.
  - Next state is HALT if `halt_req`, else FETCH.
- TRAP: for one cycle, `pc_we`=1, `pc_sel`=11, `trap`=1. `cause` is updated on entry. Next state is HALT if `halt_req`, else FETCH. `instret` does not increment.
- HALT: all strobes are 0. Return to FETCH on the first cycle with `halt_req`=0.
- Wait counter (`TO_W` bits):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle spent in FETCH/MEM without ready.
  - When it reaches `TIMEOUT`-1 without ready, go to TRAP with cause 3.
  - If ready arrives in the same cycle the limit is reached, ready wins.
- `halt_req` is sampled only in WB, TRAP and HALT. It never aborts an instruction mid-flight.
- `instret` wraps from 0xFFFFFFFF to 0.
- Outputs are Moore-decoded from `state`, except `rf_we` and `pc_sel`, which also depend on the class decoded from `inst`. `pc_sel` is 00 in every state except WB and TRAP.

## Timing
- Reset (asynchronous, any time, including mid-MEM):
  - `state`=FETCH, wait counter=0, `cause`=0, `instret`=0.
  - While `reset`=1, every strobe output is 0. `imem_req` is gated by `!reset`.
  - A pending memory access is abandoned; memories must tolerate a dropped request.
- Latency with zero-wait memory:
  - ALU/branch/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - ECALL/illegal: 3 cycles (FETCH, DECODE, TRAP).
- Each cycle of memory wait adds exactly 1 cycle.
- `pc_we` is a single-cycle pulse per instruction or trap. The PC register updates on the rising edge ending WB or TRAP.
- `ir_we` pulses exactly once per fetch, in the cycle `imem_ready`=1.
- `dmem_req` is held continuously from MEM entry until `dmem_ready`.

## Test plan
- Reset, then OP-IMM `32'h00100093`, imem zero-wait: state sequence 0,1,2,4,0. In WB, `rf_we`=1, `pc_we`=1, `pc_sel`=00. After WB, `instret`=1.
- STORE `32'h00112023` with `dmem_ready` after 3 wait cycles: MEM lasts 4 cycles with `dmem_req`=`dmem_we`=1 throughout. WB has `rf_we`=0. Total latency 8 cycles.
- ECALL `32'h00000073`: DECODE goes to TRAP; TRAP has `trap`=1, `pc_sel`=11, `pc_we`=1; `cause`=1; `instret` unchanged. Then opcode `7'b1111111` gives `cause`=2.
- `imem_ready` held low, `TIMEOUT`=4: TRAP entered after 4 FETCH cycles with `cause`=3. Repeat with `imem_ready` arriving in the 4th cycle: DECODE entered, no trap.
- JAL `32'h0080006F` with `halt_req`=1 during WB: WB has `pc_sel`=10, then state=6 with all strobes 0. Deassert `halt_req`: FETCH on the next cycle.
- Assert `reset` in the 2nd MEM cycle of a LOAD: `state`=0 and `dmem_req`=0 immediately (asynchronous). After release, the fetch restarts and `instret`=0.
